// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: bus widths, chip-enable levels,
// stall-vector bit positions and the default reset PC.
package if_stage_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned STALL_W = 6;

  localparam int unsigned STALL_PC_BIT = 0;
  localparam int unsigned STALL_IF_BIT = 1;
  localparam int unsigned STALL_ID_BIT = 2;

  localparam logic [ADDR_W-1:0] InstAddrZero     = 32'h0000_0000;
  localparam logic [INST_W-1:0] ZeroWord         = 32'h0000_0000;
  localparam logic              ChipEnable       = 1'b1;
  localparam logic              ChipDisable      = 1'b0;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;

endpackage

// File: rtl/if_stage_if.sv
// Control inputs, ROM bus and IF/ID latch outputs of the fetch stage.
// id_adel_o exists only when FETCH_ADEL_EN is defined.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic [INST_W-1:0]  rom_inst_i;
  logic               rom_ce_o;
  logic [ADDR_W-1:0]  rom_addr_o;
  logic [ADDR_W-1:0]  id_pc_o;
  logic [INST_W-1:0]  id_inst_o;
`ifdef FETCH_ADEL_EN
  logic               id_adel_o;

  modport master (
    input  stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
  );
  modport slave (
    output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
  );
`else
  modport master (
    input  stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o
  );
  modport slave (
    output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o
  );
`endif
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with chip-enable register; PC update priority is
// flush > PC stall > taken branch > sequential +4.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce
);

  logic              ce_d;
  logic              ce_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next-state: ce rises once after reset; PC waits at RESET_PC until then.
  always_comb begin
    ce_d = ChipEnable;
    pc_d = pc_q;
    if (ce_q == ChipDisable) begin
      pc_d = RESET_PC;
    end else if (flush) begin
      pc_d = new_pc;
    end else if (stall_pc) begin
      // A branch seen during a stall is dropped; ID re-presents it.
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q <= ChipDisable;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ce_d;
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
  assign ce = ce_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM from the PC and registers {pc, inst} into IF/ID.
// Optional FETCH_ADEL_EN flags misaligned fetches instead of reading the ROM.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  logic [ADDR_W-1:0] pc_s;
  logic              ce_s;
  logic              fetch_en_s;
  logic              stall_if_s;
  logic              stall_id_s;
  logic [ADDR_W-1:0] id_pc_d;
  logic [ADDR_W-1:0] id_pc_q;
  logic [INST_W-1:0] id_inst_d;
  logic [INST_W-1:0] id_inst_q;
  logic              adel_s;
  logic              id_adel_d;
  logic              id_adel_q;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (bus.stall[STALL_PC_BIT]),
    .flush         (bus.flush),
    .new_pc        (bus.new_pc),
    .branch_flag   (bus.branch_flag_i),
    .branch_target (bus.branch_target_i),
    .pc            (pc_s),
    .ce            (ce_s)
  );

`ifdef FETCH_ADEL_EN
  assign adel_s     = ce_s && (pc_s[1:0] != 2'b00);
`else
  assign adel_s     = 1'b0;
`endif
  assign fetch_en_s = ce_s && !adel_s;
  assign stall_if_s = bus.stall[STALL_IF_BIT];
  assign stall_id_s = bus.stall[STALL_ID_BIT];

  // IF/ID next value: flush bubble > IF-only stall bubble > hold > fetch.
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_adel_d = id_adel_q;
    if (bus.flush) begin
      id_pc_d   = InstAddrZero;
      id_inst_d = ZeroWord;
      id_adel_d = 1'b0;
    end else if (stall_if_s && !stall_id_s) begin
      id_pc_d   = InstAddrZero;
      id_inst_d = ZeroWord;
      id_adel_d = 1'b0;
    end else if (stall_if_s) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
      id_adel_d = id_adel_q;
    end else begin
      id_pc_d   = ce_s ? pc_s : InstAddrZero;
      id_inst_d = fetch_en_s ? bus.rom_inst_i : ZeroWord;
      id_adel_d = adel_s;
    end
  end

  // IF/ID latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q   <= InstAddrZero;
      id_inst_q <= ZeroWord;
      id_adel_q <= 1'b0;
    end else begin
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_adel_q <= id_adel_d;
    end
  end

  assign bus.rom_ce_o   = fetch_en_s;
  assign bus.rom_addr_o = pc_s;
  assign bus.id_pc_o    = id_pc_q;
  assign bus.id_inst_o  = id_inst_q;
`ifdef FETCH_ADEL_EN
  assign bus.id_adel_o  = id_adel_q;
`endif

endmodule
